// File: rtl/flex_down_timer.sv
// flex_down_timer: programmable down-counting timer with one-shot and periodic
// (auto-reload) modes. Count, expire strobe and done flag are all registered;
// busy is decoded from the state register alone.
module flex_down_timer #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    count_enable,
  input  logic                    periodic,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expire_pulse,
  output logic                    done_flag,
  output logic                    busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] CntOne = NUM_CNT_BITS'(1);

  state_e                  r_state;
  state_e                  w_state_d;
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_count_d;
  logic [NUM_CNT_BITS-1:0] r_reload;
  logic [NUM_CNT_BITS-1:0] w_reload_d;
  logic                    r_expire;
  logic                    w_expire_d;
  logic                    r_done;
  logic                    w_done_d;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_reload <= '0;
      r_expire <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_reload <= w_reload_d;
      r_expire <= w_expire_d;
      r_done   <= w_done_d;
    end
  end

  // Next-state logic; priority is clear, then load, then start/stop, then count.
  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_reload_d = r_reload;
    w_expire_d = 1'b0;
    w_done_d   = r_done;

    if (clear) begin
      w_state_d  = StIdle;
      w_count_d  = '0;
      w_reload_d = '0;
      w_done_d   = 1'b0;
    end else if (load) begin
      // Load aborts any run in progress and leaves the timer parked in idle.
      w_state_d  = StIdle;
      w_count_d  = load_val;
      w_reload_d = load_val;
      w_done_d   = 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_done_d = 1'b0;
            if (r_count != '0) begin
              // Resume from a stopped count.
              w_state_d = StRun;
            end else if (r_reload != '0) begin
              w_count_d = r_reload;
              w_state_d = StRun;
            end else begin
              // Zero-length timer expires immediately.
              w_state_d  = StDone;
              w_expire_d = 1'b1;
              w_done_d   = 1'b1;
            end
          end
        end
        StRun: begin
          if (stop) begin
            w_state_d = StIdle;
          end else if (count_enable) begin
            if (r_count > CntOne) begin
              w_count_d = r_count - CntOne;
            end else if (r_count == CntOne) begin
              w_expire_d = 1'b1;
              if (periodic) begin
                w_count_d = r_reload;
              end else begin
                w_count_d = '0;
                w_done_d  = 1'b1;
                w_state_d = StDone;
              end
            end
            // A zero count never decrements, so there is no wrap.
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  assign count_out    = r_count;
  assign expire_pulse = r_expire;
  assign done_flag    = r_done;
  assign busy         = (r_state == StRun);

endmodule

// File: tb/tb_flex_down_timer.sv
// Scoreboard bench for flex_down_timer: stimulus pushes hand-computed expected
// outputs, a monitor pops and compares after each clock edge.
module tb_flex_down_timer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         xp;
    logic         dn;
    logic         bz;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         count_enable;
  logic         periodic;
  logic [W-1:0] count_out;
  logic         expire_pulse;
  logic         done_flag;
  logic         busy;

  exp_t  q_exp[$];
  string q_name[$];
  exp_t  m_e;
  string m_nm;
  int    n_checks = 0;
  int    n_errors = 0;
  event  ev_async;

  flex_down_timer #(
    .NUM_CNT_BITS(W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .count_enable(count_enable),
    .periodic    (periodic),
    .count_out   (count_out),
    .expire_pulse(expire_pulse),
    .done_flag   (done_flag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic cyc(input string name, input logic cl, input logic ld,
                     input logic [W-1:0] lv, input logic st, input logic sp,
                     input logic en, input logic per, input logic [W-1:0] ec,
                     input logic ee, input logic ed, input logic eb);
    @(negedge clk);
    clear        = cl;
    load         = ld;
    load_val     = lv;
    start        = st;
    stop         = sp;
    count_enable = en;
    periodic     = per;
    q_exp.push_back({ec, ee, ed, eb});
    q_name.push_back(name);
  endtask

  // Pull reset low between edges and check outputs before any clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    @(negedge clk);
    #2;
    n_rst        = 1'b0;
    clear        = 1'b0;
    load         = 1'b0;
    load_val     = '0;
    start        = 1'b0;
    stop         = 1'b0;
    count_enable = 1'b0;
    periodic     = 1'b0;
    q_exp.push_back({W'(0), 1'b0, 1'b0, 1'b0});
    q_name.push_back("async_rst_mid_run");
    ->ev_async;
    #2;
    n_rst = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge.
  initial begin
    forever begin
      @(posedge clk or ev_async);
      #1;
      if (q_exp.size() != 0) begin
        m_e  = q_exp.pop_front();
        m_nm = q_name.pop_front();
        n_checks++;
        if ({count_out, expire_pulse, done_flag, busy} !== m_e) begin
          n_errors++;
          $display("FAIL %s: got cnt=%0d exp=%0b done=%0b busy=%0b, want cnt=%0d exp=%0b done=%0b busy=%0b",
                   m_nm, count_out, expire_pulse, done_flag, busy,
                   m_e.cnt, m_e.xp, m_e.dn, m_e.bz);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst        = 1'b0;
    clear        = 1'b0;
    load         = 1'b0;
    load_val     = '0;
    start        = 1'b0;
    stop         = 1'b0;
    count_enable = 1'b0;
    periodic     = 1'b0;

    // Reset values
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;

    // One-shot 5
    cyc("os_load",  0, 1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc("os_start", 0, 0, 0, 1, 0, 1, 0, 5, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("os_dec", 0, 0, 0, 0, 0, 1, 0, W'(4 - i), 0, 0, 1);
    cyc("os_expire",    0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    cyc("os_done_hold", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    // Periodic 3
    cyc("per_load",  0, 1, 3, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc("per_start", 0, 0, 0, 1, 0, 1, 1, 3, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      cyc("per_dec2",   0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1);
      cyc("per_dec1",   0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
      cyc("per_reload", 0, 0, 0, 0, 0, 1, 1, 3, 1, 0, 1);
    end
    cyc("load_aborts_run", 0, 1, 2, 0, 0, 1, 1, 2, 0, 0, 0);

    // Enable toggling 1010...
    cyc("gap_load",  0, 1, 6, 0, 0, 0, 0, 6, 0, 0, 0);
    cyc("gap_start", 0, 0, 0, 1, 0, 0, 0, 6, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      cyc("gap_toggle", 0, 0, 0, 0, 0, (i % 2 == 0), 0, W'(5 - i / 2), 0, 0, 1);
    cyc("gap_expire", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    cyc("gap_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Stop / resume; start during run is ignored
    cyc("sr_load",  0, 1, 8, 0, 0, 0, 0, 8, 0, 0, 0);
    cyc("sr_start", 0, 0, 0, 1, 0, 0, 0, 8, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("sr_dec", 0, 0, 0, (i == 1), 0, 1, 0, W'(7 - i), 0, 0, 1);
    cyc("stop_wins", 0, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    cyc("idle_hold", 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc("resume",    0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("resume_dec", 0, 0, 0, 0, 0, 1, 0, W'(3 - i), 0, 0, 1);
    cyc("resume_expire", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    cyc("resume_done",   0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    // Zero load: immediate expiry, restart from done
    cyc("z_load",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("z_start",       0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc("z_hold",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("done_stop_ign", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("z_restart",     0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc("z_hold2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Periodic with reload 1, then one-shot expiry and restart from done
    cyc("r1_load",  0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc("r1_start", 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("r1_pulse", 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1);
    cyc("r1_noen",        0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc("r1_oneshot",     0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    cyc("done_restart",   0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    cyc("r1_stop",        0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);

    // Clear beats load in the same cycle, reload register cleared too
    cyc("cl_load",       0, 1, 9, 0, 0, 0, 0, 9, 0, 0, 0);
    cyc("cl_start",      0, 0, 0, 1, 0, 0, 0, 9, 0, 0, 1);
    cyc("cl_dec",        0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1);
    cyc("clear_wins",    1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("clear_reload0", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);

    // Asynchronous reset mid-run
    cyc("ar_load",  0, 1, 9, 0, 0, 0, 0, 9, 0, 0, 0);
    cyc("ar_start", 0, 0, 0, 1, 0, 0, 0, 9, 0, 0, 1);
    cyc("ar_dec",   0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1);
    async_reset_check();
    cyc("rst_reload0", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q_exp.size() != 0; i++) @(posedge clk);
    #2;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
